// File: rtl/uart_fifo_pkg.sv
// Shared helpers for the UART sync FIFO: the count-width calculation and
// the parameter-set sanity check used at elaboration.
package uart_fifo_pkg;

    // Width needed to hold an occupancy value from 0 up to depth inclusive.
    function automatic int count_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A parameter set is legal when the depth is a power of two of at
    // least 2 and the almost-empty level sits strictly below almost-full.
    function automatic bit params_ok(input int depth, input int af_level,
                                     input int ae_level);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (ae_level < af_level);
    endfunction

endpackage

// File: rtl/uart_sync_fifo_if.sv
// Host-side handshake and status bundle of the UART sync FIFO.
interface uart_sync_fifo_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = count_bits(FIFO_DEPTH);

    logic                 flush;
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 rd_en;
    logic                 clear_err;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic [CW-1:0]        count;
    logic                 empty;
    logic                 full;
    logic                 almost_empty;
    logic                 almost_full;
    logic                 overflow;
    logic                 underflow;

    // Requester side: issues pushes, pops, flushes and error clears.
    modport master (
        output flush, wr_en, wr_data, rd_en, clear_err,
        input  rd_data, rd_valid, count, empty, full, almost_empty,
               almost_full, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  flush, wr_en, wr_data, rd_en, clear_err,
        output rd_data, rd_valid, count, empty, full, almost_empty,
               almost_full, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module uart_fifo_mem #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int PW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PW-1:0]        waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [PW-1:0]        raddr,
    output logic [DATA_BITS-1:0] rdata
);
    logic [DATA_BITS-1:0] mem [DEPTH];

    // Store the incoming word at the write pointer.
    // NOTE: the array has no reset; emptiness is tracked by pointers and
    // count, so stale contents are never observed and the array can map
    // onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock circular-buffer FIFO between the UART and the host reader,
// with level count, threshold flags, sticky errors, flush and FWFT option.
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 1
) (
    input logic             clk,
    input logic             rst_n,
    uart_sync_fifo_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = count_bits(FIFO_DEPTH);

    if (!params_ok(FIFO_DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("uart_sync_fifo: depth must be a power of two >= 2 and AE_LEVEL < AF_LEVEL");
    end

    logic [PW-1:0]        wptr, rptr;
    logic [CW-1:0]        count_q;
    logic                 ovf_q, udf_q;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 empty_w, full_w;
    logic                 rd_ok, wr_ok, ovf_evt, udf_evt;

    // Flags decode only the registered count, never the request inputs.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(FIFO_DEPTH));

    // A write into a full FIFO is still taken when a read frees a slot in
    // the same cycle; a write never rescues a read of an empty FIFO.
    assign rd_ok   = bus.rd_en && !empty_w;
    assign wr_ok   = bus.wr_en && (!full_w || rd_ok);
    assign ovf_evt = !bus.flush && bus.wr_en && !wr_ok;
    assign udf_evt = !bus.flush && bus.rd_en && empty_w;

    // Pointer, count and sticky error state; flush beats read/write.
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (bus.flush) begin
                wptr    <= '0;
                rptr    <= '0;
                count_q <= '0;
            end else begin
                if (wr_ok) wptr <= wptr + PW'(1);
                if (rd_ok) rptr <= rptr + PW'(1);
                if (wr_ok && !rd_ok)      count_q <= count_q + CW'(1);
                else if (rd_ok && !wr_ok) count_q <= count_q - CW'(1);
            end
            // A fresh error in the same cycle outranks the clear.
            ovf_q <= ovf_evt || (ovf_q && !bus.clear_err);
            udf_q <= udf_evt || (udf_q && !bus.clear_err);
        end
    end

    uart_fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (FIFO_DEPTH),
        .PW        (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok && !bus.flush),
        .waddr (wptr),
        .wdata (bus.wr_data),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; forced to zero while empty so the
        // output never exposes stale or uninitialised storage.
        assign bus.rd_data  = empty_w ? '0 : mem_rdata;
        assign bus.rd_valid = !empty_w;
    end else begin : g_registered
        logic [DATA_BITS-1:0] rd_data_q;
        logic                 rd_valid_q;

        // Capture the head word on an accepted pop; valid pulses one cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_ok && !bus.flush;
                if (rd_ok && !bus.flush) rd_data_q <= mem_rdata;
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_uart_sync_fifo.sv
// Self-checking bench: one FWFT and one registered-read FIFO driven with
// identical stimulus and compared against a queue-based reference model.
module tb_uart_sync_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          flush, wr_en, rd_en, clear_err;
    logic [DB-1:0] wr_data;

    uart_sync_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) if1 ();
    uart_sync_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) if0 ();

    assign if1.flush = flush;  assign if1.wr_en = wr_en;  assign if1.wr_data = wr_data;
    assign if1.rd_en = rd_en;  assign if1.clear_err = clear_err;
    assign if0.flush = flush;  assign if0.wr_en = wr_en;  assign if0.wr_data = wr_data;
    assign if0.rd_en = rd_en;  assign if0.clear_err = clear_err;

    uart_sync_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF),
                     .AE_LEVEL(AE), .FWFT(1)) dut_fwft (.clk(clk), .rst_n(rst_n), .bus(if1));
    uart_sync_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF),
                     .AE_LEVEL(AE), .FWFT(0)) dut_reg (.clk(clk), .rst_n(rst_n), .bus(if0));

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DB-1:0] q[$];
    logic          m_ovf, m_udf, m_rv0;
    logic [DB-1:0] m_rd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rv0 = 1'b0; m_rd0 = '0;
    endtask

    // Apply the FIFO rules to one clock edge using the pre-edge state.
    task automatic model_step();
        bit rd_ok, wr_ok, ovf_ev, udf_ev;
        if (flush) begin
            q.delete();
            m_rv0 = 1'b0;
            ovf_ev = 0; udf_ev = 0;
        end else begin
            rd_ok  = rd_en && (q.size() > 0);
            wr_ok  = wr_en && ((q.size() < DEPTH) || rd_ok);
            ovf_ev = wr_en && !wr_ok;
            udf_ev = rd_en && (q.size() == 0);
            m_rv0  = rd_ok;
            if (rd_ok) m_rd0 = q.pop_front();
            if (wr_ok) q.push_back(wr_data);
        end
        m_ovf = ovf_ev || (m_ovf && !clear_err);
        m_udf = udf_ev || (m_udf && !clear_err);
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count",        32'(if1.count),        32'(n));
        check("empty",        32'(if1.empty),        32'(n == 0));
        check("full",         32'(if1.full),         32'(n == DEPTH));
        check("almost_empty", 32'(if1.almost_empty), 32'(n <= AE));
        check("almost_full",  32'(if1.almost_full),  32'(n >= AF));
        check("overflow",     32'(if1.overflow),     32'(m_ovf));
        check("underflow",    32'(if1.underflow),    32'(m_udf));
        check("fwft_rd_data", 32'(if1.rd_data),      (n > 0) ? 32'(q[0]) : 32'h0);
        check("fwft_rd_valid",32'(if1.rd_valid),     32'(n > 0));
        check("reg_count",    32'(if0.count),        32'(n));
        check("reg_rd_data",  32'(if0.rd_data),      32'(m_rd0));
        check("reg_rd_valid", 32'(if0.rd_valid),     32'(m_rv0));
        check("reg_overflow", 32'(if0.overflow),     32'(m_ovf));
        check("reg_underflow",32'(if0.underflow),    32'(m_udf));
    endtask

    // One clock: drive, let the edge happen, update model, sample 1 ns later.
    task automatic cycle(input logic f, input logic we, input logic [DB-1:0] wd,
                         input logic re, input logic ce);
        flush = f; wr_en = we; wr_data = wd; rd_en = re; clear_err = ce;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    typedef struct {
        logic          we;
        logic [DB-1:0] wd;
        logic          re;
        logic          ce;
        int            e_count;
        logic [DB-1:0] e_data;
        logic          e_full;
        logic          e_af;
        logic          e_ovf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 8'hA1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 2, 8'hA1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 3, 8'hA1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'hD4, 1'b0, 1'b0, 4, 8'hA1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 4, 8'hA1, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 8'hA1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 8'hEE, 1'b0, 1'b1, 4, 8'hA1, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 8'hA1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 8'hB2, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'hC3, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'hD4, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        flush = 0; wr_en = 0; wr_data = '0; rd_en = 0; clear_err = 0;
        model_reset();
        #3;
        check_all();
        #9 rst_n = 1'b1;

        // Fill, overflow, clear, clear-vs-new-error, drain.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].ce);
            check($sformatf("vec%0d_count", i), 32'(if1.count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d_data", i),  32'(if1.rd_data), 32'(vecs[i].e_data));
            check($sformatf("vec%0d_full", i),  32'(if1.full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d_af", i),    32'(if1.almost_full), 32'(vecs[i].e_af));
            check($sformatf("vec%0d_ovf", i),   32'(if1.overflow), 32'(vecs[i].e_ovf));
        end
        check("drain_empty", 32'(if1.empty), 32'h1);

        // Full with simultaneous read/write across pointer wrap.
        cycle(0, 1, 8'hA1, 0, 0);
        cycle(0, 1, 8'hB2, 0, 0);
        cycle(0, 1, 8'hC3, 0, 0);
        cycle(0, 1, 8'hD4, 0, 0);
        cycle(0, 1, 8'h55, 1, 0);
        check("rw_full_head", 32'(if1.rd_data), 32'hB2);
        check("rw_full_flag", 32'(if1.full), 32'h1);
        for (int i = 0; i < 10; i++) cycle(0, 1, DB'(8'h60 + i), 1, 0);
        check("wrap_head", 32'(if1.rd_data), 32'h66);

        // Flush at count 3 with read and write pending.
        cycle(0, 0, 8'h00, 1, 0);
        check("pre_flush_count", 32'(if1.count), 32'h3);
        cycle(1, 1, 8'h99, 1, 0);
        check("flush_count", 32'(if1.count), 32'h0);
        check("flush_errs", {if1.overflow, if1.underflow}, 32'h0);
        check("flush_reg_valid", 32'(if0.rd_valid), 32'h0);

        // Read of empty with same-cycle write.
        cycle(0, 1, 8'h77, 1, 0);
        check("udf_flag", 32'(if1.underflow), 32'h1);
        check("udf_count", 32'(if1.count), 32'h1);
        check("udf_data", 32'(if1.rd_data), 32'h77);
        cycle(0, 0, 8'h00, 0, 1);

        // Asynchronous reset mid-burst, sampled with no clock edge.
        cycle(0, 1, 8'h12, 0, 0);
        cycle(0, 1, 8'h34, 1, 0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("arst_count", 32'(if1.count), 32'h0);
        check("arst_flags", {if1.empty, if1.almost_empty, if1.full, if1.almost_full}, 32'b1100);
        check("arst_reg", {if0.rd_valid, if0.rd_data}, 32'h0);
        check_all();
        flush = 0; wr_en = 0; rd_en = 0; clear_err = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Registered read: one-cycle valid pulse, data holds afterwards.
        cycle(0, 1, 8'h3C, 0, 0);
        check("reg_before_valid", 32'(if0.rd_valid), 32'h0);
        cycle(0, 0, 8'h00, 1, 0);
        check("reg_pulse", {if0.rd_valid, if0.rd_data}, 32'h13C);
        cycle(0, 0, 8'h00, 0, 0);
        check("reg_hold", {if0.rd_valid, if0.rd_data}, 32'h03C);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), DB'($urandom),
                  ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
